// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), odd parity, 1+ stop bits.
// Good bytes are written to the RX FIFO; dropped bytes raise a one-cycle error pulse.
module uart_rx #(
    parameter int DIV         = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic       full_i,
    output logic       we_o,
    output logic [7:0] data_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int          HALF     = DIV / 2;
    localparam logic [15:0] CNT_LAST = 16'(DIV - 1);
    localparam logic [15:0] CNT_HALF = 16'(HALF);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   sample;
    state_t                 state;
    logic [15:0]            cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic                   par_ok;

    // Synchroniser resets to the idle-high line level so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign sample = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            par_ok       <= 1'b0;
            we_o         <= 1'b0;
            data_o       <= '0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            // NOTE: pulses default low each cycle, so any branch that sets one yields exactly one clock.
            we_o         <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        busy_o <= 1'b1;
                        if (HALF == 0) begin
                            state   <= DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end else begin
                            state <= START;
                            cnt   <= 16'd1;
                        end
                    end
                end

                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (sample) begin
                        shreg[bit_idx] <= rx_s;
                        cnt            <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                PARITY: begin
                    if (sample) begin
                        par_ok <= ^{shreg, rx_s};
                        state  <= STOP;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                STOP: begin
                    if (sample) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            frame_err_o <= 1'b1;
                            state       <= WAIT_HIGH;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            if (!par_ok) begin
                                parity_err_o <= 1'b1;
                            end else if (full_i) begin
                                overrun_o <= 1'b1;
                            end else begin
                                we_o   <= 1'b1;
                                data_o <= shreg;
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                // A break holds the line low; wait for it to recover before hunting for a start bit.
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

endmodule
